// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states, owner
// tags and access-fault exception codes also consumed by the trap handler.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [3:0] EXC_INSTR_ACCESS = 4'd1;
    localparam logic [3:0] EXC_LOAD_ACCESS  = 4'd5;
    localparam logic [3:0] EXC_STORE_ACCESS = 4'd7;

    function automatic logic [3:0] access_fault_code(input owner_e owner, input logic we);
        if (owner == OWN_FETCH) return EXC_INSTR_ACCESS;
        return we ? EXC_STORE_ACCESS : EXC_LOAD_ACCESS;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data access onto one 64-bit memory port,
// one transaction at a time, with bus-error and timeout fault reporting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_wstrb,
    output logic [63:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        stall,
    output logic        exc_en,
    output logic [3:0]  exc_code,
    output logic [63:0] exc_val
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    owner_e           owner;
    logic [63:0]      lat_addr;
    logic [63:0]      lat_wdata;
    logic             lat_we;
    logic [7:0]       lat_wstrb;

    logic take_d, take_if;
    logic resp_take, timeout_hit, complete, fault;

    // A requester still shows req during its own *_valid cycle; masking it
    // here keeps the same request from being issued twice.
    assign take_d  = d_req & ~d_valid;
    assign take_if = if_req & ~if_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        resp_take   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (take_d || take_if) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    cnt_nxt = '0;
                    if (mem_rvalid) begin
                        resp_take = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    resp_take = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_DRAIN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // The abandoned response may still arrive; swallow it here.
                if (mem_rvalid || cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        complete  = resp_take | timeout_hit;
        fault     = timeout_hit | (resp_take & mem_err);
        mem_req   = (state == ST_REQ);
        mem_we    = lat_we;
        mem_addr  = {lat_addr[63:3], 3'b000};
        mem_wdata = lat_wdata;
        mem_wstrb = lat_wstrb;
        stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_FETCH;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_wstrb <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            exc_en    <= 1'b0;
            exc_code  <= '0;
            exc_val   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            exc_en   <= 1'b0;
            exc_code <= '0;
            exc_val  <= '0;

            if (state == ST_IDLE) begin
                if (take_d) begin
                    owner     <= OWN_DATA;
                    lat_addr  <= d_addr;
                    lat_we    <= d_we;
                    lat_wdata <= d_wdata;
                    lat_wstrb <= d_wstrb;
                end else if (take_if) begin
                    owner     <= OWN_FETCH;
                    lat_addr  <= if_addr;
                    lat_we    <= 1'b0;
                    lat_wdata <= '0;
                    lat_wstrb <= '0;
                end
            end

            if (complete) begin
                if (owner == OWN_FETCH) begin
                    if_valid <= 1'b1;
                    if_rdata <= fault ? 32'd0 :
                                (lat_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]);
                end else begin
                    d_valid <= 1'b1;
                    d_rdata <= (fault || lat_we) ? 64'd0 : mem_rdata;
                end
                if (fault) begin
                    exc_en   <= 1'b1;
                    exc_code <= access_fault_code(owner, lat_we);
                    exc_val  <= lat_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: the bench plays the
// memory and both requesters cycle by cycle against hand-computed values.
module tb_mem_port_arbiter;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wstrb;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        stall;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .stall(stall), .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic all_ok;

        rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_wstrb = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
        nxt(); nxt();
        check("rst_if_valid", if_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_exc_en", exc_en, 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;

        // Fetch at 0x1004: gnt after one REQ cycle, response two cycles into WAIT.
        nxt();
        if_req = 1; if_addr = 64'h1004;
        #1;
        check("f_stall_pending", stall, 1);
        check("f_idle_no_req", mem_req, 0);
        nxt();
        check("f_req", mem_req, 1);
        check("f_addr_aligned", mem_addr, 64'h1000);
        check("f_we", mem_we, 0);
        check("f_wstrb", mem_wstrb, 0);
        nxt();
        check("f_req_held", mem_req, 1);
        check("f_stall_held", stall, 1);
        mem_gnt = 1;
        nxt();
        mem_gnt = 0;
        check("f_req_dropped", mem_req, 0);
        check("f_no_early_valid", if_valid, 0);
        nxt();
        mem_rvalid = 1; mem_rdata = 64'hAAAAAAAA_00000013;
        nxt();
        check("f_valid", if_valid, 1);
        check("f_rdata_hi", if_rdata, 32'hAAAAAAAA);
        check("f_stall_low", stall, 0);
        check("f_no_d_valid", d_valid, 0);
        check("f_no_exc", exc_en, 0);
        mem_rvalid = 0; if_req = 0;
        nxt();
        check("f_valid_one_pulse", if_valid, 0);

        // Simultaneous store and fetch: data wins, fetch issued right after d_valid.
        if_req = 1; if_addr = 64'h1008;
        d_req = 1; d_we = 1; d_addr = 64'h2008; d_wdata = 64'h55; d_wstrb = 8'h01;
        nxt();
        check("s_req", mem_req, 1);
        check("s_we", mem_we, 1);
        check("s_wstrb", mem_wstrb, 8'h01);
        check("s_addr", mem_addr, 64'h2008);
        check("s_wdata", mem_wdata, 64'h55);
        mem_gnt = 1;
        nxt();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hDEAD;
        nxt();
        check("s_d_valid", d_valid, 1);
        check("s_store_rdata_zero", d_rdata, 0);
        check("s_if_not_valid", if_valid, 0);
        check("s_stall_fetch_pending", stall, 1);
        mem_rvalid = 0; d_req = 0; d_we = 0;
        nxt();
        check("s_fetch_req", mem_req, 1);
        check("s_fetch_addr", mem_addr, 64'h1008);
        check("s_fetch_we", mem_we, 0);
        check("s_fetch_wstrb", mem_wstrb, 0);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h11111111_22222222;
        nxt();
        check("s_fetch_valid_same_cycle", if_valid, 1);
        check("s_fetch_rdata_lo", if_rdata, 32'h22222222);
        mem_gnt = 0; mem_rvalid = 0; if_req = 0;
        nxt();

        // Load with bus error at 0x3000.
        d_req = 1; d_we = 0; d_addr = 64'h3000; d_wstrb = 8'hFF;
        nxt();
        mem_gnt = 1;
        nxt();
        mem_gnt = 0; mem_rvalid = 1; mem_err = 1; mem_rdata = 64'hFFFF;
        nxt();
        check("e_d_valid", d_valid, 1);
        check("e_rdata_zero", d_rdata, 0);
        check("e_exc_en", exc_en, 1);
        check("e_exc_code", exc_code, 4'd5);
        check("e_exc_val", exc_val, 64'h3000);
        mem_rvalid = 0; mem_err = 0; d_req = 0;
        nxt();
        check("e_exc_one_pulse", exc_en, 0);
        check("e_d_valid_one_pulse", d_valid, 0);

        // Normal load, gnt and rvalid together.
        d_req = 1; d_we = 0; d_addr = 64'h3010;
        nxt();
        check("l_addr", mem_addr, 64'h3010);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h01234567_89ABCDEF;
        nxt();
        check("l_d_valid", d_valid, 1);
        check("l_rdata", d_rdata, 64'h01234567_89ABCDEF);
        check("l_no_exc", exc_en, 0);
        mem_gnt = 0; mem_rvalid = 0; d_req = 0;
        nxt();

        // Fetch at 0x8000 never granted: mem_req high exactly T cycles, then fault.
        if_req = 1; if_addr = 64'h8000;
        nxt();
        all_ok = mem_req;
        for (int i = 1; i < T; i++) begin
            nxt();
            if (!mem_req || if_valid) all_ok = 1'b0;
        end
        check("t_req_held_T_cycles", all_ok, 1);
        nxt();
        check("t_req_dropped", mem_req, 0);
        check("t_if_valid", if_valid, 1);
        check("t_if_rdata_zero", if_rdata, 0);
        check("t_exc_en", exc_en, 1);
        check("t_exc_code", exc_code, 4'd1);
        check("t_exc_val", exc_val, 64'h8000);
        if_req = 0;
        nxt();

        // Timeout in WAIT, then late response swallowed in DRAIN.
        if_req = 1; if_addr = 64'h9004;
        nxt();
        mem_gnt = 1;
        nxt();
        mem_gnt = 0;
        all_ok = 1'b1;
        for (int i = 1; i < T; i++) begin
            nxt();
            if (if_valid || mem_req) all_ok = 1'b0;
        end
        check("w_quiet_during_wait", all_ok, 1);
        nxt();
        check("w_if_valid", if_valid, 1);
        check("w_exc_en", exc_en, 1);
        check("w_exc_code", exc_code, 4'd1);
        check("w_exc_val", exc_val, 64'h9004);
        if_req = 0;
        nxt();
        check("w_drain_no_valid", if_valid, 0);
        if_req = 1; if_addr = 64'hA000;
        mem_rvalid = 1; mem_rdata = 64'hBEEF;
        #1;
        check("w_drain_stall", stall, 1);
        check("w_drain_no_issue", mem_req, 0);
        nxt();
        mem_rvalid = 0;
        check("w_late_not_forwarded", if_valid, 0);
        check("w_late_no_exc", exc_en, 0);
        check("w_idle_no_req", mem_req, 0);
        nxt();
        check("w_next_req", mem_req, 1);
        check("w_next_addr", mem_addr, 64'hA000);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h33333333_44444444;
        nxt();
        check("w_next_valid", if_valid, 1);
        check("w_next_rdata", if_rdata, 32'h44444444);
        check("w_next_no_exc", exc_en, 0);
        mem_gnt = 0; mem_rvalid = 0; if_req = 0;
        nxt();

        // Reset while a load waits for its response.
        d_req = 1; d_we = 0; d_addr = 64'h4000;
        nxt();
        mem_gnt = 1;
        nxt();
        mem_gnt = 0;
        rst = 1; d_req = 0;
        nxt();
        check("r_mem_req", mem_req, 0);
        check("r_mem_addr", mem_addr, 0);
        check("r_mem_we", mem_we, 0);
        check("r_mem_wstrb", mem_wstrb, 0);
        check("r_if_rdata", if_rdata, 0);
        check("r_d_rdata", d_rdata, 0);
        check("r_d_valid", d_valid, 0);
        check("r_exc_code", exc_code, 0);
        check("r_exc_val", exc_val, 0);
        check("r_stall", stall, 0);
        rst = 0;
        mem_rvalid = 1; mem_rdata = 64'h5555;
        nxt();
        mem_rvalid = 0;
        check("r_late_no_d_valid", d_valid, 0);
        check("r_late_no_if_valid", if_valid, 0);
        nxt();
        check("r_idle_after", mem_req, 0);
        check("r_no_valid_after", d_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified 64-bit memory port between instruction fetch and data load/store, replacing the separate imem/dmem paths of the single-cycle core.
- Serialises requests: one outstanding transaction at a time.
- Drives a stall to the PC enable while any access is in flight.
- Flags access faults and timeouts using the codebase exc_en/exc_code/exc_val triple, which feeds the trap handler's exception mux.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ or WAIT before a transaction is aborted with a fault
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, single domain
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held high until if_valid
if_addr  in  64  fetch address (pc_addr), 4-byte aligned
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held high until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  64  data address (ALU result)
d_wdata  in  64  store data
d_wstrb  in  8  byte strobes (dmem_word_sel)
d_rdata  out  64  load data
d_valid  out  1  one-cycle data completion pulse
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write enable
mem_addr  out  64  address, 8-byte aligned (addr[63:3],3'b0)
mem_wdata  out  64  write data
mem_wstrb  out  8  write strobes
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  response (read data or write ack)
mem_rdata  in  64  read data
mem_err  in  1  bus error, qualified by mem_rvalid
stall  out  1  to pc_en (inverted at top): high while a request is pending
exc_en  out  1  one-cycle fault pulse
exc_code  out  4  1 instr access fault, 5 load access fault, 7 store access fault
exc_val  out  64  faulting address

Behaviour:
- Reset (synchronous): state IDLE, counter 0, owner FETCH. All outputs 0 on the edge after rst is sampled high. This holds mid-transaction; a late mem_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - If d_req, latch owner=DATA plus d_addr, d_we, d_wdata, d_wstrb, then go to REQ.
  - Else if if_req, latch owner=FETCH plus if_addr with we=0 and wstrb=0, then go to REQ.
  - Data has priority on simultaneous requests. A data request belongs to the already-fetched instruction, so fetch cannot starve.
- REQ:
  - mem_req=1; mem_* are driven from latched registers only and stay stable until gnt.
  - On mem_gnt, go to WAIT with counter cleared.
  - mem_gnt and mem_rvalid in the same cycle is legal: complete directly and return to IDLE.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, the completion cycle is the next cycle: registered *_valid=1 for owner.
  - if_rdata = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - d_rdata = mem_rdata for loads, 0 for stores.
  - Then IDLE. Back-to-back: a new request can enter REQ the cycle after *_valid.
- Error: if mem_rvalid & mem_err, assert the owner's *_valid with rdata=0, and pulse exc_en in the same cycle.
  - exc_code: 1 for FETCH, 5 for load, 7 for store.
  - exc_val: the latched address (unaligned original).
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - At TIMEOUT_CYCLES in REQ: drop mem_req, complete with fault as above, go to IDLE. The memory contract is no response to a request withdrawn before gnt.
  - At TIMEOUT_CYCLES in WAIT: complete with fault, go to DRAIN.
- DRAIN: discard responses; leave on mem_rvalid or after another TIMEOUT_CYCLES; no new request is issued meanwhile.
- mem_rvalid in IDLE or REQ is discarded.
- stall = (if_req & ~if_valid) | (d_req & ~d_valid), combinational. It is low in the *_valid cycle so the PC and regfile commit exactly once.
- A requester dropping *_req mid-transaction is illegal. The transaction still completes and *_valid is still pulsed.

Decomposition:
- Shared package (mem_arb_pkg): state encoding, owner enum, and EXC_INSTR_ACCESS=4'd1, EXC_LOAD_ACCESS=4'd5, EXC_STORE_ACCESS=4'd7. The exception constants are reused by imem, dmem and the trap handler.
- No sub-module: FSM, counter and response mux live in one module.

Test Plan:
- Fetch only: if_req=1 with if_addr=0x1004, mem_gnt 1 cycle after mem_req, mem_rvalid 2 cycles later with mem_rdata=0xAAAAAAAA_00000013 -> mem_addr=0x1000, if_rdata=0xAAAAAAAA, single if_valid pulse, stall high until that cycle.
- Simultaneous if_req and d_req (store, d_addr=0x2008, d_wdata=0x55, d_wstrb=0x01) -> data issued first with mem_we=1 and mem_wstrb=0x01; fetch issued the cycle after d_valid.
- mem_rvalid with mem_err on a load at d_addr=0x3000 -> d_valid=1, d_rdata=0, exc_en=1, exc_code=5, exc_val=0x3000, for exactly one cycle.
- mem_gnt held low for TIMEOUT_CYCLES during a fetch at 0x8000 -> mem_req drops, if_valid=1, exc_code=1, exc_val=0x8000.
- Timeout in WAIT, then a late mem_rvalid -> state passes through DRAIN, the late response is not forwarded, and the next fetch completes normally.
- rst asserted in WAIT -> all outputs 0 next cycle; a subsequent mem_rvalid produces no *_valid.
